// File: rtl/inverse_wavelet_transform_if.sv
// Coefficient-in / sample-out bundle for the inverse 5/3 wavelet block.
// Handshake: a coefficient pair moves on a rising edge where in_valid and
// in_ready are both 1; the source holds coef_s/coef_d stable while in_valid=1
// and in_ready=0. The output side has no back-pressure: out_valid qualifies
// data_out_even/data_out_odd/line_done/frame_done for exactly that cycle.
interface inverse_wavelet_transform_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] coef_s;
    logic [15:0] coef_d;
    logic        out_valid;
    logic [15:0] data_out_even;
    logic [15:0] data_out_odd;
    logic        line_done;
    logic        frame_done;

    modport master (
        output in_valid, coef_s, coef_d,
        input  in_ready, out_valid, data_out_even, data_out_odd, line_done, frame_done
    );

    modport slave (
        input  in_valid, coef_s, coef_d,
        output in_ready, out_valid, data_out_even, data_out_odd, line_done, frame_done
    );
endinterface

// File: rtl/inverse_wavelet_transform.sv
// Row-wise inverse integer 5/3 lifting. Each accepted (s[n], d[n]) pair
// produces e[n]; the output pair n-1 is formed once e[n] is known, so a line
// ends with a one-cycle FLUSH that emits the last pair using the mirrored
// right neighbour e[P] = e[P-1].
module inverse_wavelet_transform #(
    parameter  int PAIRS_PER_LINE = 32,
    parameter  int LINES          = 64,
    localparam int PW = (PAIRS_PER_LINE > 1) ? $clog2(PAIRS_PER_LINE) : 1,
    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    inverse_wavelet_transform_if.slave bus,
    output logic [1:0]                 o_dbg_state,
    output logic [PW-1:0]              o_dbg_pair_cnt,
    output logic [LW-1:0]              o_dbg_line_cnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [PW-1:0] LAST_PAIR = PW'(PAIRS_PER_LINE - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);

    logic [1:0]         r_state;
    logic [PW-1:0]      r_pair_cnt;
    logic [LW-1:0]      r_line_cnt;
    logic signed [17:0] r_d_prev;
    logic signed [17:0] r_e_prev;
    logic               r_out_valid;
    logic               r_line_done;
    logic               r_frame_done;
    logic [15:0]        r_even;
    logic [15:0]        r_odd;

    logic               w_in_ready;
    logic               w_accept;
    logic signed [17:0] w_s;
    logic signed [17:0] w_d;
    logic signed [17:0] w_d_left;
    logic signed [17:0] w_e_new;
    logic signed [17:0] w_e_right;
    logic signed [17:0] w_even_full;
    logic signed [17:0] w_odd_full;

    // Clamp an 18-bit intermediate into the signed 16-bit output range.
    function automatic logic [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'h7FFF;
        else if (v < -18'sd32768)
            return 16'h8000;
        else
            return v[15:0];
    endfunction

    // Lifting datapath: even update on the incoming pair, odd update on the stored one.
    always_comb begin
        w_in_ready  = (r_state != S_FLUSH);
        w_accept    = bus.in_valid && w_in_ready;
        w_s         = {{2{bus.coef_s[15]}}, bus.coef_s};
        w_d         = {{2{bus.coef_d[15]}}, bus.coef_d};
        // At line start there is no d[-1]; mirror d[0].
        w_d_left    = (r_state == S_IDLE) ? w_d : r_d_prev;
        w_e_new     = w_s - ((w_d_left + w_d + 18'sd2) >>> 2);
        // In FLUSH there is no e[n+1]; mirror the last even sample.
        w_e_right   = (r_state == S_FLUSH) ? r_e_prev : w_e_new;
        // The odd update must see the unsaturated evens.
        w_even_full = r_e_prev;
        w_odd_full  = r_d_prev + ((r_e_prev + w_e_right) >>> 1);
    end

    // Line sequencing, stored lifting operands and the registered output pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pair_cnt   <= '0;
            r_line_cnt   <= '0;
            r_d_prev     <= '0;
            r_e_prev     <= '0;
            r_out_valid  <= 1'b0;
            r_line_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_even       <= '0;
            r_odd        <= '0;
        end else begin
            r_out_valid  <= 1'b0;
            r_line_done  <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (w_accept) begin
                        r_d_prev <= w_d;
                        r_e_prev <= w_e_new;
                        // Pair 0 only primes the stored operands.
                        if (r_state == S_RUN) begin
                            r_even      <= sat16(w_even_full);
                            r_odd       <= sat16(w_odd_full);
                            r_out_valid <= 1'b1;
                        end
                        if (r_pair_cnt == LAST_PAIR) begin
                            r_state    <= S_FLUSH;
                            r_pair_cnt <= '0;
                        end else begin
                            r_state    <= S_RUN;
                            r_pair_cnt <= r_pair_cnt + PW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    r_even       <= sat16(w_even_full);
                    r_odd        <= sat16(w_odd_full);
                    r_out_valid  <= 1'b1;
                    r_line_done  <= 1'b1;
                    r_frame_done <= (r_line_cnt == LAST_LINE);
                    r_line_cnt   <= (r_line_cnt == LAST_LINE) ? '0 : r_line_cnt + LW'(1);
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.data_out_even = r_even;
    assign bus.data_out_odd  = r_odd;
    assign bus.line_done     = r_line_done;
    assign bus.frame_done    = r_frame_done;

    assign o_dbg_state    = r_state;
    assign o_dbg_pair_cnt = r_pair_cnt;
    assign o_dbg_line_cnt = r_line_cnt;
endmodule

// File: doc/inverse_wavelet_transform.md
INVERSE_WAVELET_TRANSFORM -- requirements
Module: inverse_wavelet_transform

Interface
REQ-001 The block SHALL have parameter PAIRS_PER_LINE, default 32: coefficient pairs per image line.
REQ-002 The block SHALL have parameter LINES, default 64: lines per frame.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the coefficient pair is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a pair this cycle.
REQ-007 The block SHALL have port coef_s, input, 16 bits: signed lowpass (approximation) coefficient s[n].
REQ-008 The block SHALL have port coef_d, input, 16 bits: signed highpass (detail) coefficient d[n].
REQ-009 The block SHALL have port out_valid, output, 1 bit: the reconstructed pair is present.
REQ-010 The block SHALL have port data_out_even, output, 16 bits: signed reconstructed sample x[2n].
REQ-011 The block SHALL have port data_out_odd, output, 16 bits: signed reconstructed sample x[2n+1].
REQ-012 The block SHALL have port line_done, output, 1 bit: one-cycle pulse with the last pair of a line.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse with the last pair of the last line.

Function
REQ-014 The block SHALL perform the row-wise inverse integer 5/3 lifting transform that reconstructs samples from pairs produced by the forward wavelet transform block.
REQ-015 A pair SHALL be accepted on any rising edge where in_valid=1 and in_ready=1; when in_valid=0, the state SHALL hold and out_valid SHALL be 0.
REQ-016 The even sample SHALL be computed as e[n] = s[n] - floor((d[n-1] + d[n] + 2) / 4), with d[-1] = d[0] at each line start (symmetric extension).
REQ-017 The odd sample SHALL be computed as o[n] = d[n] + floor((e[n] + e[n+1]) / 2), with e[PAIRS_PER_LINE] = e[PAIRS_PER_LINE-1] at each line end.
REQ-018 All arithmetic SHALL be performed in 18-bit signed; floor SHALL be an arithmetic right shift.
REQ-019 o[n] SHALL use the unsaturated e[n] and e[n+1].
REQ-020 Both outputs SHALL saturate to [-32768, 32767].
REQ-021 The states SHALL be IDLE, RUN and FLUSH.
REQ-022 IDLE->RUN SHALL occur on acceptance of pair 0 of a line; pair 0 SHALL produce no output.
REQ-023 In RUN, acceptance of pair n (n>=1) SHALL register output pair n-1, with out_valid=1 on the next cycle (latency 1 accepted pair + 1 clk).
REQ-024 Acceptance of pair PAIRS_PER_LINE-1 SHALL emit pair PAIRS_PER_LINE-2 and move the state to FLUSH.
REQ-025 In FLUSH, in_ready SHALL be 0 for exactly one cycle, and the block SHALL register pair PAIRS_PER_LINE-1 with line_done=1 and then return to IDLE.
REQ-026 in_ready SHALL be 1 in IDLE and RUN.
REQ-027 in_valid asserted during FLUSH SHALL NOT consume a pair; the source holds it.
REQ-028 pair_cnt SHALL run 0..PAIRS_PER_LINE-1 and line_cnt 0..LINES-1; line_cnt SHALL increment on the FLUSH cycle.
REQ-029 frame_done SHALL assert with line_done when line_cnt=LINES-1, after which line_cnt SHALL wrap to 0.
REQ-030 Gaps in in_valid at any point in a line SHALL NOT change the results.

Reset
REQ-031 When rst_n=0 at a rising edge, the block SHALL clear the state to IDLE, clear pair_cnt, line_cnt and the stored d/e registers, and drive out_valid, line_done, frame_done, data_out_even and data_out_odd to 0 and in_ready to 1 from the next cycle.
REQ-032 Reset mid-line SHALL discard the partial line; the next accepted pair SHALL be treated as pair 0 of line 0.

Verification
REQ-033 The bench SHALL check: one line with s=100, d=0 for all pairs -> 32 outputs, each even=100 and odd=100, line_done only on the 32nd output.
REQ-034 The bench SHALL check: one line with s=10, d=4 for all pairs -> every even=8 and odd=12, including pair 0 and pair 31 (boundary extension).
REQ-035 The bench SHALL check: in_valid held high continuously -> in_ready=0 for exactly one cycle after pair 31 is accepted, and the held pair is accepted as pair 0 of the next line.
REQ-036 The bench SHALL check: one line with s=32767, d=-32768 -> even saturates to 32767 and odd=16383.
REQ-037 The bench SHALL check: 64 lines at the 34-cycle source cadence -> 64 line_done pulses, a single frame_done coincident with the last one, and line_cnt back at 0.
REQ-038 The bench SHALL check: rst_n=0 for one cycle after 10 pairs -> all outputs 0, and the restarted line reproduces the REQ-034 values.
